// File: rtl/inst_scheduler_if.sv
// Instance hand-off channel between inst_scheduler (master) and frame_driver (slave).
interface inst_scheduler_if #(
  parameter int IID_W = 8
);
  logic             inst_valid;
  logic             inst_ready;
  logic [IID_W-1:0] inst_id;
  logic             inst_done;

  modport master (output inst_valid, output inst_id, input inst_ready, input inst_done);
  modport slave  (input inst_valid, input inst_id, output inst_ready, output inst_done);
endinterface

// File: rtl/inst_scheduler.sv
// inst_scheduler: per-frame instance sequencer feeding frame_driver.
// Walks slots 0..inst_count-1, reads each enable flag, offers enabled IDs one at a
// time and waits for their completion before moving on.
// Optional build macro SCHED_TIMEOUT_EN adds a per-instance WAIT watchdog that
// sets the sticky sched_err and abandons the stuck instance.
module inst_scheduler #(
  parameter int MAX_INST = 256,
  parameter int RD_LAT   = 1,
  parameter int TIMEOUT  = 4096,
  localparam int IID_W   = $clog2(MAX_INST)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [IID_W:0]   inst_count,
  output logic [IID_W-1:0] rd_inst_id,
  input  logic             inst_en,
  inst_scheduler_if.master drv,
  output logic             frame_busy,
  output logic             frame_done,
  output logic [IID_W:0]   inst_drawn,
  output logic             sched_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int             LAT_W   = $clog2(RD_LAT + 1);
  localparam logic [IID_W:0] MAX_CNT = (IID_W + 1)'(MAX_INST);

  logic [2:0]       state;
  logic [IID_W-1:0] slot;
  logic [IID_W:0]   cnt_q;
  logic [LAT_W-1:0] lat_cnt;
  logic             last_slot;
  logic             wd_hit;

  // The slot counter drives both the memory address and the offered ID, so the
  // two are identical whenever an instance is being offered.
  assign rd_inst_id     = slot;
  assign drv.inst_id    = slot;
  assign drv.inst_valid = (state == S_ISSUE);
  assign last_slot      = ({1'b0, slot} == (cnt_q - (IID_W + 1)'(1)));

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wdog;

  // A real inst_done in the expiry cycle wins, so no error is raised for it.
  assign wd_hit = (state == S_WAIT) && (wdog == WD_W'(TIMEOUT - 1)) && !drv.inst_done;

  // Watchdog: zero outside WAIT, counts WAIT cycles, latches a sticky error on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog      <= '0;
      sched_err <= 1'b0;
    end else begin
      if (state != S_WAIT) wdog <= '0;
      else                 wdog <= wdog + WD_W'(1);
      if (wd_hit) sched_err <= 1'b1;
    end
  end
`else
  assign wd_hit    = 1'b0;
  assign sched_err = 1'b0;
`endif

  // Frame sequencer: slot walk, enable check, handshake, completion wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      slot       <= '0;
      cnt_q      <= '0;
      lat_cnt    <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      inst_drawn <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            cnt_q      <= (inst_count > MAX_CNT) ? MAX_CNT : inst_count;
            slot       <= '0;
            lat_cnt    <= '0;
            inst_drawn <= '0;
            frame_busy <= 1'b1;
            state      <= (inst_count == '0) ? S_DONE : S_FETCH;
          end
        end
        // One cycle to launch the address plus RD_LAT cycles for the flag to return.
        S_FETCH: begin
          if (lat_cnt == LAT_W'(RD_LAT)) begin
            lat_cnt <= '0;
            state   <= S_CHECK;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        S_CHECK: begin
          if (inst_en) begin
            state <= S_ISSUE;
          end else if (last_slot) begin
            state <= S_DONE;
          end else begin
            slot  <= slot + IID_W'(1);
            state <= S_FETCH;
          end
        end
        // inst_done is not looked at here, so a pulse coinciding with the transfer is dropped.
        S_ISSUE: begin
          if (drv.inst_ready) begin
            inst_drawn <= inst_drawn + (IID_W + 1)'(1);
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (drv.inst_done || wd_hit) begin
            if (last_slot) begin
              state <= S_DONE;
            end else begin
              slot  <= slot + IID_W'(1);
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          frame_done <= 1'b1;
          frame_busy <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
